// File: rtl/dma_addr_gen_p.sv
// Am2940-style DMA address / word-count generator with configurable widths,
// halt-on-done and an auto-reinitialise ring-buffer mode.
module dma_addr_gen_p #(
  parameter int AW = 16,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] din,
  input  logic [2:0]    instr,
  input  logic          aci,
  input  logic          wci,
  output logic          aco,
  output logic          wco,
  output logic          done,
  output logic [AW-1:0] dout,
  output logic          dout_vld,
  output logic [AW-1:0] addr_out
);

  localparam logic [2:0] I_WRCR   = 3'd0;
  localparam logic [2:0] I_RDCR   = 3'd1;
  localparam logic [2:0] I_RDWC   = 3'd2;
  localparam logic [2:0] I_RDAC   = 3'd3;
  localparam logic [2:0] I_REINIT = 3'd4;
  localparam logic [2:0] I_LDADDR = 3'd5;
  localparam logic [2:0] I_LDWC   = 3'd6;
  localparam logic [2:0] I_ENCT   = 3'd7;

  logic [2:0]    cr_q, cr_d;
  logic [AW-1:0] ar_q, ar_d;
  logic [AW-1:0] ac_q, ac_d;
  logic [CW-1:0] wcr_q, wcr_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [AW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;
  logic          pulse_q, pulse_d;

  logic [1:0]    mode;
  logic          cnt_down;
  logic          done_c;
  logic          halt;
  logic          reload;
  logic [AW-1:0] ac_step;
  logic [CW-1:0] wc_step;

  assign mode     = cr_q[1:0];
  // Modes 00 and 11 count WC down; 01 and 10 count it up.
  assign cnt_down = (mode[1] == mode[0]);

  always_comb begin
    done_c = 1'b0;
    case (mode)
      2'b00:   done_c = (wc_q == CW'(1));
      2'b01:   done_c = (wc_q == wcr_q);
      2'b10:   done_c = (ac_q[CW-1:0] == wcr_q);
      default: done_c = pulse_q;
    endcase
  end

  assign halt    = (mode != 2'b11) && done_c;
  assign reload  = (instr == I_ENCT) && (mode == 2'b11) && wci && (wc_q == CW'(1));
  assign ac_step = cr_q[2] ? (ac_q - AW'(1)) : (ac_q + AW'(1));
  assign wc_step = cnt_down ? (wc_q - CW'(1)) : (wc_q + CW'(1));

  always_comb begin
    cr_d       = cr_q;
    ar_d       = ar_q;
    ac_d       = ac_q;
    wcr_d      = wcr_q;
    wc_d       = wc_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    pulse_d    = 1'b0;
    case (instr)
      I_WRCR: begin
        cr_d = din[2:0];
        if (din[1] ^ din[0]) wc_d = '0;
      end
      I_RDCR: begin
        dout_d     = {{(AW-3){1'b1}}, cr_q};
        dout_vld_d = 1'b1;
      end
      I_RDWC: begin
        dout_d     = AW'(wc_q);
        dout_vld_d = 1'b1;
      end
      I_RDAC: begin
        dout_d     = ac_q;
        dout_vld_d = 1'b1;
      end
      I_REINIT: begin
        ac_d = ar_q;
        wc_d = cnt_down ? wcr_q : '0;
      end
      I_LDADDR: begin
        ar_d = din;
        ac_d = din;
      end
      I_LDWC: begin
        wcr_d = din[CW-1:0];
        wc_d  = cnt_down ? din[CW-1:0] : '0;
      end
      I_ENCT: begin
        // Ring-buffer completion reloads both counters instead of stepping.
        if (reload) begin
          ac_d    = ar_q;
          wc_d    = wcr_q;
          pulse_d = 1'b1;
        end else if (!halt) begin
          if (aci) ac_d = ac_step;
          if (wci) wc_d = wc_step;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cr_q       <= '0;
      ar_q       <= '0;
      ac_q       <= '0;
      wcr_q      <= '0;
      wc_q       <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      cr_q       <= cr_d;
      ar_q       <= ar_d;
      ac_q       <= ac_d;
      wcr_q      <= wcr_d;
      wc_q       <= wc_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      pulse_q    <= pulse_d;
    end
  end

  assign aco      = aci & (cr_q[2] ? (ac_q == '0) : (ac_q == '1));
  assign wco      = wci & (cnt_down ? (wc_q == '0) : (wc_q == '1));
  assign done     = done_c;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign addr_out = ac_q;

endmodule

// File: doc/dma_addr_gen_p.md
Name: dma_addr_gen_p

Overview:
- Parametrised, next-generation DMA address/word-count generator for the Am2940-style datapath.
- Holds an address register and counter, a word-count register and counter, and a 3-bit control register. All are driven by a 3-bit instruction each clock.
- Compared with the 8-bit block, it adds:
  - configurable address and count widths,
  - a halt-on-done stall,
  - an auto-reinitialise (ring-buffer) mode that reloads both counters on completion.

Parameters:
- AW, 16, address register/counter width (bits); also DOUT width.
- CW, 12, word-count register/counter width; CW <= AW is required.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- din  in  AW  load data; CR uses din[2:0], WCR uses din[CW-1:0]
- instr  in  3  instruction, sampled every rising edge
- aci  in  1  address count enable (carry-in), active high
- wci  in  1  word count enable (carry-in), active high
- aco  out  1  address carry-out, combinational
- wco  out  1  word carry-out, combinational
- done  out  1  transfer complete
- dout  out  AW  registered read-back data
- dout_vld  out  1  high the cycle after a read instruction
- addr_out  out  AW  address counter value AC

Behaviour:
- Reset (synchronous, active high) has priority over every instruction. Reset values:
  - CR=0, AR=0, AC=0, WCR=0, WC=0
  - dout=0, dout_vld=0, done=0
- CR fields:
  - CR[2]: address direction. 0 = increment AC, 1 = decrement AC.
  - CR[1:0] = 00, WC-down: done = (WC==1).
  - CR[1:0] = 01, WC-up: done = (WC==WCR).
  - CR[1:0] = 10, address-compare: done = (AC[CW-1:0]==WCR).
  - CR[1:0] = 11, auto-reinit: WC counts down; done is a registered 1-cycle pulse on reload.
- Instruction set:
  - 0 WRCR: CR<=din[2:0]. If the new mode is 01 or 10, WC<=0.
  - 1 RDCR: dout<={ones(AW-3),CR}.
  - 2 RDWC: dout<=zero-extended WC.
  - 3 RDAC: dout<=AC.
  - 4 REINIT: AC<=AR. WC<=WCR in modes 00/11; WC<=0 in modes 01/10.
  - 5 LDADDR: AR<=din and AC<=din in the same cycle.
  - 6 LDWC: WCR<=din[CW-1:0]. WC<=din in modes 00/11; WC<=0 in modes 01/10.
  - 7 ENCT: counters step per the counting rules below.
- Read latency: dout updates on the edge that samples instr 1/2/3; dout_vld=1 for exactly that following cycle. dout holds its value otherwise.
- Counting (only under ENCT):
  - AC steps +/-1 per CR[2] iff aci=1.
  - WC steps (down in 00/11, up in 01/10) iff wci=1.
  - Both wrap modulo 2^AW / 2^CW.
- Halt: in modes 00/01/10, while done=1, ENCT does not step AC or WC.
- Auto-reinit (mode 11): when ENCT with wci=1 and WC==1:
  - next edge loads WC<=WCR and AC<=AR instead of stepping,
  - done=1 for that one following cycle.
  - WCR=0 means 2^CW words per block.
- aco = aci & (AC==all-ones when incrementing, AC==0 when decrementing). Independent of instr.
- wco = wci & (WC==0 in modes 00/11, WC==all-ones in modes 01/10).
- Loading WC=0 in mode 00 counts 2^CW words: it wraps to all-ones and proceeds down to 1.
- Mode changes via WRCR mid-transfer take effect on the next cycle. Counters are untouched except as stated for WRCR.
- Reset asserted mid-transfer clears everything on that edge, including a pending auto-reinit done pulse.

Test Plan:
- reset; WRCR din=0x0003; RDCR -> dout=0xFFFB, dout_vld=1 for one cycle; aco=wco=done=0.
- Mode 00, LDADDR 0x1000, LDWC 4, ENCT aci=wci=1 -> addr_out 0x1001,0x1002,0x1003; done=1 when WC==1. Further ENCT holds AC=0x1003, WC=1.
- Mode 100 (decrement), LDADDR 0x0001, LDWC 3, ENCT -> AC 0x0000 with aco=1, then 0xFFFF; done when WC==1.
- Mode 01, LDWC 5 (WC=0), ENCT with wci toggling 1,0,1,1,1,1 -> WC reaches 5 after 5 enabled cycles, done=1, halt.
- Mode 11, LDADDR 0x2000, LDWC 2, continuous ENCT -> addr 0x2001, reload 0x2000; done pulses 1 cycle every 2 cycles; WC sequence 2,1,2,1.
- Mode 00 mid-transfer: assert reset for one cycle during ENCT -> next cycle all registers 0, dout_vld=0, done=0; REINIT afterwards gives AC=0, WC=0.
